// File: rtl/secuenciador_formato_hora.sv
// Writes the requested RTC format flags as a two-word sequence (INI, FIN) over a
// valid/ready bus, with auto-update on flag change, request queuing and timeout.
module secuenciador_formato_hora #(
   parameter int         DATA_W   = 8,
   parameter int         N_FLAGS  = 2,
   parameter int         FLAG_LSB = 3,
   parameter logic [2:0] CMD_INI  = 3'b000,
   parameter logic [2:0] CMD_FIN  = 3'b001,
   parameter bit         AUTO_UPD = 1'b1,
   parameter int         TO_CYC   = 255
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [N_FLAGS-1:0] flags,
   output logic [DATA_W-1:0]  wr_data,
   output logic               wr_valid,
   input  logic               wr_ready,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [N_FLAGS-1:0] flags_act
);

   generate
      if (DATA_W < 3 + N_FLAGS + FLAG_LSB) begin : g_bad_layout
         $error("secuenciador_formato_hora: DATA_W too small for command and flag fields");
      end
   endgenerate

   // Counter holds TO_CYC itself; a disabled timeout still needs one bit.
   localparam int CW = (TO_CYC == 0) ? 1 : $clog2(TO_CYC + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'((TO_CYC == 0) ? 0 : TO_CYC - 1);

   typedef enum logic [1:0] {
      IDLE,
      SEND_WI,
      SEND_WF,
      FIN
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic [N_FLAGS-1:0] flags_q;
   logic               pending_q;
   logic [CW-1:0]      cnt_q;
   logic               err_q;

   logic               request;
   logic               new_req_busy;
   logic               timeout;
   logic [2:0]         cmd;

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_d      = state_q;
      request      = start || pending_q || (AUTO_UPD && (flags != flags_act));
      new_req_busy = start || (AUTO_UPD && (flags != flags_q));
      timeout      = (TO_CYC != 0) && !wr_ready && (cnt_q == CNT_LAST);
      busy         = (state_q != IDLE);
      done         = (state_q == FIN);
      wr_valid     = (state_q == SEND_WI) || (state_q == SEND_WF);
      cmd          = (state_q == SEND_WF) ? CMD_FIN : CMD_INI;
      wr_data      = '0;
      if (wr_valid) begin
         wr_data[DATA_W-1 -: 3]        = cmd;
         wr_data[FLAG_LSB +: N_FLAGS]  = flags_q;
      end

      case (state_q)
         IDLE: begin
            if (request) state_d = SEND_WI;
         end
         SEND_WI: begin
            if (wr_ready)     state_d = SEND_WF;
            else if (timeout) state_d = IDLE;
         end
         SEND_WF: begin
            if (wr_ready)     state_d = FIN;
            else if (timeout) state_d = IDLE;
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign err = err_q;

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // sees the values from before the edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         flags_q   <= '0;
         flags_act <= '0;
         pending_q <= 1'b0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (request) begin
                  flags_q   <= flags;
                  pending_q <= 1'b0;
                  cnt_q     <= '0;
               end
            end
            SEND_WI, SEND_WF: begin
               if (new_req_busy) pending_q <= 1'b1;
               if (wr_ready) begin
                  cnt_q <= '0;
               end else begin
                  if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                  if (timeout)     err_q <= 1'b1;
               end
            end
            FIN: begin
               if (new_req_busy) pending_q <= 1'b1;
               flags_act <= flags_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/secuenciador_formato_hora.md
SECUENCIADOR_FORMATO_HORA -- requirements
Module: secuenciador_formato_hora

Interface
REQ-001 Parameter DATA_W, default 8: width of each RTC write data word.
REQ-002 Parameter N_FLAGS, default 2: number of format flag bits (bit 1 = SF_24_12, bit 0 = SF_Timer).
REQ-003 Parameter FLAG_LSB, default 3: bit position of the flag field LSB in each word.
REQ-004 Parameters CMD_INI, default 3'b000, and CMD_FIN, default 3'b001: 3-bit command codes in word bits [DATA_W-1:DATA_W-3].
REQ-005 Parameter AUTO_UPD, default 1: 1 = a flag change starts a sequence without start.
REQ-006 Parameter TO_CYC, default 255: maximum cycles wr_valid waits for wr_ready; a TO_CYC of 0 disables the timeout.
REQ-007 clk  input  1  single clock; all logic updates on the rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 start  input  1  one-cycle request to write the current flags.
REQ-010 flags  input  N_FLAGS  requested format flags.
REQ-011 wr_data  output  DATA_W  word offered to the RTC bus driver.
REQ-012 wr_valid  output  1  wr_data is valid.
REQ-013 wr_ready  input  1  the bus driver accepts wr_data.
REQ-014 busy  output  1  a sequence is in progress.
REQ-015 done  output  1  one-cycle pulse when a sequence completes.
REQ-016 err  output  1  one-cycle pulse when a sequence aborts on timeout.
REQ-017 flags_act  output  N_FLAGS  the flags of the last completed sequence.

Function
REQ-018 Elaboration shall fail unless DATA_W >= 3 + N_FLAGS + FLAG_LSB.
REQ-019 Word layout: command in the top 3 bits, flags_q in [FLAG_LSB+N_FLAGS-1:FLAG_LSB], all other bits 0; with default parameters, word = {cmd, SF_24_12, SF_Timer, 3'b000}.
REQ-020 FSM states: IDLE, SEND_WI, SEND_WF, FIN; after reset the FSM is in IDLE.
REQ-021 In IDLE, a request is any of: start=1; AUTO_UPD=1 and flags != flags_act; pending=1.
REQ-022 When a request occurs in IDLE: latch flags into flags_q, clear pending, enter SEND_WI.
REQ-023 Latency: with a request at edge T, wr_valid=1 with wr_data = {CMD_INI, flags_q} from T+1.
REQ-024 In SEND_WI and SEND_WF, wr_valid shall stay 1 and wr_data shall stay stable until an edge where wr_ready=1; that edge is the transfer.
REQ-025 A transfer in SEND_WI enters SEND_WF, with the next cycle wr_data = {CMD_FIN, flags_q}.
REQ-026 A transfer in SEND_WF enters FIN.
REQ-027 In FIN, for exactly one cycle: done=1, wr_valid=0, flags_act<=flags_q; the next state is IDLE.
REQ-028 busy=1 in SEND_WI, SEND_WF and FIN; otherwise busy=0.
REQ-029 In IDLE and FIN, wr_valid=0 and wr_data=0.
REQ-030 Minimum sequence length is 3 cycles after the request (wr_ready tied high): WI, WF, FIN.
REQ-031 If start=1, or a flag change with AUTO_UPD=1, occurs while busy=1, pending is set; flags_q shall not change during the sequence.
REQ-032 After FIN, a set pending bit starts a new sequence from IDLE using the flags current at that edge.
REQ-033 A wait counter resets to 0 on entry to each SEND state and increments each cycle wr_ready=0.
REQ-034 If TO_CYC != 0 and the wait counter reaches TO_CYC: err=1 for one cycle, wr_valid drops, the FSM enters IDLE, flags_act is unchanged, pending is unchanged.
REQ-035 Under AUTO_UPD=1, a differing flags value re-triggers the sequence after a timeout.
REQ-036 start and a flag change in the same IDLE cycle produce one sequence only.
REQ-037 The wait counter width shall be ceil(log2(TO_CYC+1)) bits and shall not wrap.

Reset
REQ-038 Reset at any state, including mid-sequence, shall give next edge: state IDLE, wr_valid=0, wr_data=0, busy=0, done=0, err=0, flags_act=0, flags_q=0, pending=0, wait counter=0.
REQ-039 reset has priority over start, wr_ready and flag changes in the same cycle.

Verification
REQ-040 Defaults, wr_ready=1, flags=2'b10, start pulse at T -> wr_data 8'h10 at T+1, 8'h30 at T+2, done at T+3, flags_act=2'b10.
REQ-041 wr_ready held 0 for 5 cycles in SEND_WI -> wr_valid=1 and wr_data=8'h08 (flags=01) stable throughout; WF follows the first wr_ready=1.
REQ-042 AUTO_UPD=1, flags changed 00->11 with no start -> one sequence, words 8'h18 then 8'h38, done pulse.
REQ-043 Flags change during SEND_WF -> the current sequence finishes with old flags, then a second sequence runs with new flags.
REQ-044 TO_CYC=4, wr_ready=0 -> err pulse after 4 wait cycles, busy=0, flags_act unchanged, and the auto retry starts.
REQ-045 reset asserted in SEND_WF -> next edge all outputs 0, no done; no request follows while flags=0.
